// File: rtl/water_pkg.sv
// Shared definitions for the washer water path: controller state encoding,
// fault codes and default level width (also imported by the flow monitor).
package water_pkg;

    localparam int LEVEL_W_DEFAULT = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_DRAIN,
        ST_SETTLE,
        ST_FAULT
    } state_t;

    localparam logic [1:0] FC_NONE    = 2'd0;
    localparam logic [1:0] FC_MONITOR = 2'd1;
    localparam logic [1:0] FC_TIMEOUT = 2'd2;
    localparam logic [1:0] FC_ABORT   = 2'd3;

endpackage

// File: rtl/phase_timer.sv
// Clearable, saturating up-counter shared by the phase timeout and the
// settle delay; expired flags that the current count equals the limit.
module phase_timer #(
    parameter int MAX_CYCLES = 200,
    parameter int CNT_W      = $clog2(MAX_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] limit,
    output logic             expired
);

    logic [CNT_W-1:0] count;

    // NOTE: reset is synchronous, so it is tested inside the clocked block
    // and never appears in the sensitivity list.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            // NOTE: state uses non-blocking assignment so every register
            // samples its inputs from the same pre-edge values.
            count <= count + 1'b1;
        end
    end

    assign expired = (count == limit);

endmodule

// File: rtl/water_level_controller.sv
// Fill/drain actuator controller: drives inlet valve or drain pump toward a
// latched target level, aborting into FAULT on monitor error, timeout or abort.
module water_level_controller
    import water_pkg::*;
#(
    parameter int LEVEL_W       = LEVEL_W_DEFAULT,
    parameter int SETTLE_CYCLES = 4,
    parameter int MAX_CYCLES    = 200
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_drain,
    input  logic [LEVEL_W-1:0] cmd_target,
    input  logic [LEVEL_W-1:0] water_level_sensor,
    input  logic               error_flag,
    input  logic               abort,
    output logic               valve_open,
    output logic               pump_on,
    output logic               mode,
    output logic               monitor_reset,
    output logic               busy,
    output logic               done,
    output logic               fault,
    output logic [1:0]         fault_code
);

    localparam int               CNT_W        = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] PHASE_LIMIT  = CNT_W'(MAX_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LIMIT = CNT_W'(SETTLE_CYCLES - 1);

    state_t             state_q, state_d;
    logic [LEVEL_W-1:0] target_q, target_d;
    logic               mode_d;
    logic               monitor_reset_d;
    logic               done_d;
    logic [1:0]         fault_code_d;
    logic               accept;
    logic               fill_met;
    logic               drain_met;
    logic               timer_clear;
    logic               timer_enable;
    logic               timer_expired;
    logic [CNT_W-1:0]   timer_limit;

    assign accept    = cmd_valid && cmd_ready;
    assign fill_met  = (water_level_sensor >= target_q);
    assign drain_met = (water_level_sensor <= target_q);

    // Any state change starts a fresh count, so FILL/DRAIN/SETTLE each begin at 0.
    assign timer_clear  = (state_d != state_q);
    assign timer_enable = (state_q == ST_FILL) || (state_q == ST_DRAIN) ||
                          (state_q == ST_SETTLE);
    assign timer_limit  = (state_q == ST_SETTLE) ? SETTLE_LIMIT : PHASE_LIMIT;

    phase_timer #(
        .MAX_CYCLES (MAX_CYCLES),
        .CNT_W      (CNT_W)
    ) u_phase_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (timer_clear),
        .enable  (timer_enable),
        .limit   (timer_limit),
        .expired (timer_expired)
    );

    // NOTE: every variable gets a default before the case statement so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d         = state_q;
        target_d        = target_q;
        mode_d          = mode;
        fault_code_d    = fault_code;
        monitor_reset_d = 1'b0;
        done_d          = 1'b0;

        case (state_q)
            ST_IDLE, ST_FAULT: begin
                if (accept) begin
                    target_d     = cmd_target;
                    mode_d       = !cmd_drain;
                    fault_code_d = FC_NONE;
                    if (cmd_drain) begin
                        if (water_level_sensor <= cmd_target) begin
                            state_d = ST_SETTLE;
                        end else begin
                            state_d         = ST_DRAIN;
                            monitor_reset_d = 1'b1;
                        end
                    end else begin
                        if (water_level_sensor >= cmd_target) begin
                            state_d = ST_SETTLE;
                        end else begin
                            state_d         = ST_FILL;
                            monitor_reset_d = 1'b1;
                        end
                    end
                end
            end

            // The monitor is held in reset on the first phase cycle, so its
            // error_flag is meaningless while monitor_reset is high.
            ST_FILL: begin
                if (abort) begin
                    state_d      = ST_FAULT;
                    fault_code_d = FC_ABORT;
                end else if (error_flag && !monitor_reset) begin
                    state_d      = ST_FAULT;
                    fault_code_d = FC_MONITOR;
                end else if (fill_met) begin
                    state_d = ST_SETTLE;
                end else if (timer_expired) begin
                    state_d      = ST_FAULT;
                    fault_code_d = FC_TIMEOUT;
                end
            end

            ST_DRAIN: begin
                if (abort) begin
                    state_d      = ST_FAULT;
                    fault_code_d = FC_ABORT;
                end else if (error_flag && !monitor_reset) begin
                    state_d      = ST_FAULT;
                    fault_code_d = FC_MONITOR;
                end else if (drain_met) begin
                    state_d = ST_SETTLE;
                end else if (timer_expired) begin
                    state_d      = ST_FAULT;
                    fault_code_d = FC_TIMEOUT;
                end
            end

            ST_SETTLE: begin
                if (abort) begin
                    state_d      = ST_FAULT;
                    fault_code_d = FC_ABORT;
                end else if (timer_expired) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the
    // state they describe, one edge after the deciding inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            target_q      <= '0;
            cmd_ready     <= 1'b1;
            valve_open    <= 1'b0;
            pump_on       <= 1'b0;
            mode          <= 1'b1;
            monitor_reset <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            fault         <= 1'b0;
            fault_code    <= FC_NONE;
        end else begin
            state_q       <= state_d;
            target_q      <= target_d;
            cmd_ready     <= (state_d == ST_IDLE) || (state_d == ST_FAULT);
            valve_open    <= (state_d == ST_FILL);
            pump_on       <= (state_d == ST_DRAIN);
            mode          <= mode_d;
            monitor_reset <= monitor_reset_d;
            busy          <= (state_d == ST_FILL) || (state_d == ST_DRAIN) ||
                             (state_d == ST_SETTLE);
            done          <= done_d;
            fault         <= (state_d == ST_FAULT);
            fault_code    <= fault_code_d;
        end
    end

endmodule

// File: doc/water_level_controller.md
# water_level_controller

Actuator-side controller for the washer water path: accepts fill/drain commands with a target level, drives the inlet valve or drain pump until the sensor reaches the target, and generates the `mode` and per-phase reset for the water flow monitor. It consumes the monitor's `error_flag` and a phase timeout to abort into a fault state. Sits between the cycle sequencer (command source) and the valve/pump drivers, alongside the flow monitor.

## Interface
- `LEVEL_W`, 10: width of level/target values (unsigned)
- `SETTLE_CYCLES`, 4: cycles actuators stay off after target reached before `done`
- `MAX_CYCLES`, 200: phase timeout in cycles (fill or drain), must be ≥ 2
- `clk`  in  1  system clock (one clock domain)
- `reset`  in  1  synchronous, active-high
- `cmd_valid`  in  1  command request
- `cmd_ready`  out  1  high in IDLE and FAULT; command accepted when `cmd_valid & cmd_ready` at a rising edge
- `cmd_drain`  in  1  0 = fill to target, 1 = drain to target
- `cmd_target`  in  LEVEL_W  target level
- `water_level_sensor`  in  LEVEL_W  current level
- `error_flag`  in  1  from flow monitor
- `abort`  in  1  immediate stop request
- `valve_open`  out  1  inlet valve on
- `pump_on`  out  1  drain pump on
- `mode`  out  1  to monitor: 1 = filling, 0 = draining
- `monitor_reset`  out  1  one-cycle pulse at phase start
- `busy`  out  1  high in FILL, DRAIN, SETTLE
- `done`  out  1  one-cycle completion pulse
- `fault`  out  1  high in FAULT
- `fault_code`  out  2  0 none, 1 monitor error, 2 timeout, 3 abort

## Operation
- States: IDLE, FILL, DRAIN, SETTLE, FAULT. All outputs registered.
- Reset values: state IDLE, `valve_open`=0, `pump_on`=0, `mode`=1, `monitor_reset`=0, `busy`=0, `done`=0, `fault`=0, `fault_code`=0, phase counter 0.
- IDLE/FAULT + accepted command: target latched; counter cleared; `fault`/`fault_code` cleared; go FILL (`cmd_drain`=0) or DRAIN (`cmd_drain`=1); `mode` set accordingly and held until next command.
- Target already met at acceptance (fill: level ≥ target; drain: level ≤ target): go directly to SETTLE, actuators never turn on, no `monitor_reset`.
- FILL: `valve_open`=1. Exit to SETTLE when level ≥ target. DRAIN: `pump_on`=1. Exit to SETTLE when level ≤ target. `valve_open` and `pump_on` never both 1.
- SETTLE: both actuators off; count SETTLE_CYCLES, then pulse `done` and go IDLE.
- Fault checks in FILL/DRAIN, priority: `abort` (code 3) > `error_flag` (code 1, ignored on the first phase cycle while monitor is in reset) > target reached > counter = MAX_CYCLES−1 (code 2).
- `abort` in SETTLE goes to FAULT code 3; `abort` in IDLE/FAULT ignored.
- FAULT: actuators off, `fault`=1 until next accepted command or `reset`.
- Commands presented while `cmd_ready`=0 are not accepted and not queued.
- Comparisons are unsigned LEVEL_W; no arithmetic on level, so no wrap.

## Timing
- Command accepted at edge N: FILL/DRAIN from N+1, actuator on and `monitor_reset`=1 during cycle N+1, `monitor_reset`=0 from N+2.
- Target seen at edge M: actuator off from M+1 (SETTLE); `done` high for exactly the cycle after SETTLE_CYCLES SETTLE cycles, IDLE the cycle after.
- Fault condition at edge M: actuators off and `fault`=1 from M+1.
- Timeout: phase lasts at most MAX_CYCLES cycles with actuator on.
- `reset` mid-phase: all outputs at reset values next cycle, command dropped.

## Structure
- Shared package `water_pkg`: state enum, fault code constants, default LEVEL_W; the flow monitor imports the same package.
- One sub-module `phase_timer`: clearable up-counter of width $clog2(MAX_CYCLES+1) with `expired` output, reused for timeout and settle counting.

## Test plan
- Fill: level 50, target 150, level +20 every 2 cycles -> `valve_open` from N+1, off after level 150, `done` pulse SETTLE_CYCLES later, `fault`=0.
- Drain: level 200, target 100, level −20 every 2 cycles -> `pump_on` only, `mode`=0, `done` after reaching 100.
- Monitor error: fill with `error_flag` raised at cycle 10 -> FAULT code 1 next cycle, valve off; new command clears `fault`.
- Timeout: MAX_CYCLES=20, level held 50, target 150 -> FAULT code 2, valve on exactly 20 cycles.
- Abort plus `error_flag` same cycle in DRAIN -> code 3; target already met (fill, level 300, target 200) -> no actuator, `done` after settle.
- `reset` mid-fill -> all outputs at reset values next cycle; command ignored while `busy`.
